check: RTL



---
 rtl/check_pkg.sv | 39 +++
 rtl/check_rec_writer.sv | 91 +++++++++
 rtl/check.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/check_pkg.sv
// check_pkg: shared constants for the result-checking stage, the
// stimulus-sequencer command codes and the result record layout.
package check_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int STF_W  = 24;
    localparam int ORV_W  = 8;

    localparam logic [4:0] SC_CMD_IDLE    = 5'b00000;
    localparam logic [4:0] SC_CMD_BITMASK = 5'b00001;

    localparam int CHF_ORV_LSB  = 0;
    localparam int CHF_ADDR_LSB = ORV_W;
    localparam int CHF_EXP_LSB  = ORV_W + ADDR_W;

    localparam int REC_WORDS = 4;

    typedef struct packed {
        logic              fail;
        logic [ADDR_W-1:0] addr;
        logic [ORV_W-1:0]  orv;
        logic [STF_W-1:0]  actual;
    } rec_t;

    // Word idx of a 4-word result record.
    function automatic logic [DATA_W-1:0] rec_word(input rec_t r,
                                                   input logic [1:0] idx);
        logic [DATA_W-1:0] w;
        case (idx)
            2'd0:    w = {r.fail, 3'b000, r.addr[19:16], r.orv};
            2'd1:    w = r.addr[15:0];
            2'd2:    w = {8'h00, r.actual[23:16]};
            default: w = r.actual[15:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/check_rec_writer.sv
// check_rec_writer: writes one 4-word result record over Avalon-MM
// and tracks the next free result address and the memory-full flag.
module check_rec_writer
    import check_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    DATA_WIDTH = DATA_W,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE   = ADDR_WIDTH'('h80000),
    parameter logic [ADDR_WIDTH-1:0] RES_LIMIT  = ADDR_WIDTH'('hFFFFF)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  rec_t                  rec,
    output logic                  room,
    output logic                  done,
    output logic                  res_full,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest
);

    localparam logic [2:0] W_IDLE = 3'd0;
    localparam logic [2:0] W_WR0  = 3'd1;
    localparam logic [2:0] W_WR3  = 3'd4;

    localparam logic [ADDR_WIDTH+1:0] LIMIT_X  = {2'b00, RES_LIMIT};
    localparam logic [ADDR_WIDTH+1:0] REC_SPAN = (ADDR_WIDTH+2)'(REC_WORDS - 1);

    logic [2:0]          state_q, state_d;
    // One spare bit so the address after the last record cannot wrap.
    logic [ADDR_WIDTH:0] res_addr_q, res_addr_d;
    rec_t                rec_q, rec_d;
    logic                res_full_q, res_full_d;
    logic [1:0]          wr_idx;

    assign room          = ({1'b0, res_addr_q} + REC_SPAN) <= LIMIT_X;
    assign wr_idx        = 2'(state_q - W_WR0);
    assign mem_address   = res_addr_q[ADDR_WIDTH-1:0];
    assign mem_writedata = rec_word(rec_q, wr_idx);
    assign res_full      = res_full_q;

    always_comb begin
        state_d    = state_q;
        res_addr_d = res_addr_q;
        rec_d      = rec_q;
        res_full_d = res_full_q;
        done       = 1'b0;
        mem_write  = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (start) begin
                    if (room) begin
                        state_d = W_WR0;
                        rec_d   = rec;
                    end else begin
                        res_full_d = 1'b1;
                    end
                end
            end
            default: begin
                mem_write = 1'b1;
                if (!mem_waitrequest) begin
                    res_addr_d = res_addr_q + 1'b1;
                    if (state_q == W_WR3) begin
                        state_d = W_IDLE;
                        done    = 1'b1;
                    end else begin
                        state_d = state_q + 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= W_IDLE;
            res_addr_q <= {1'b0, RES_BASE};
            rec_q      <= '0;
            res_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_addr_q <= res_addr_d;
            rec_q      <= rec_d;
            res_full_q <= res_full_d;
        end
    end

endmodule

// File: rtl/check.sv
// check: compares DUT output samples with CHECK_FIFO entries under a
// bitmask, counts pass/fail and logs result records to memory.
module check
    import check_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    DATA_WIDTH = DATA_W,
    parameter int                    BE_WIDTH   = DATA_WIDTH / 8,
    parameter int                    STF_WIDTH  = STF_W,
    parameter int                    ORV_WIDTH  = ORV_W,
    parameter int                    CHF_WIDTH  = STF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
    parameter int                    SCC_WIDTH  = 5,
    parameter int                    SCD_WIDTH  = 24,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE   = ADDR_WIDTH'('h80000),
    parameter logic [ADDR_WIDTH-1:0] RES_LIMIT  = ADDR_WIDTH'('hFFFFF),
    parameter bit                    LOG_PASS   = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [CHF_WIDTH-1:0]  cfifo_q,
    output logic                  cfifo_rdreq,
    input  logic                  cfifo_rdempty,
    input  logic [STF_WIDTH-1:0]  target_out,
    input  logic                  target_valid,
    output logic                  check_ready,
    input  logic [SCC_WIDTH-1:0]  sc_cmd,
    input  logic [SCD_WIDTH-1:0]  sc_data,
    input  logic                  sc_switching,
    output logic                  sc_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    output logic [CNT_WIDTH-1:0]  pass_cnt,
    output logic [CNT_WIDTH-1:0]  fail_cnt,
    output logic                  res_full,
    output logic                  err_underrun,
    output logic                  err_overrun
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [STF_WIDTH-1:0]  act_q, act_d, exp_q, exp_d, mask_q, mask_d;
    logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
    logic [ORV_WIDTH-1:0]  orv_q, orv_d;
    logic [CNT_WIDTH-1:0]  pass_q, pass_d, fail_q, fail_d;
    logic                  under_q, under_d, over_q, over_d;
    logic                  idle, accept, miss, log_it, start, room, done;
    rec_t                  rec;

    assign idle        = (state_q == S_IDLE);
    assign accept      = idle & target_valid & ~cfifo_rdempty;
    assign cfifo_rdreq = accept;
    assign check_ready = idle;
    assign sc_ready    = idle;
    assign miss        = |((act_q ^ exp_q) & mask_q);
    assign log_it      = miss | LOG_PASS;
    assign start       = (state_q == S_COMPARE) & log_it;
    assign rec         = '{fail: miss, addr: vaddr_q, orv: orv_q, actual: act_q};

    assign mem_byteenable = '1;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign err_underrun   = under_q;
    assign err_overrun    = over_q;

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        exp_d   = exp_q;
        vaddr_d = vaddr_q;
        orv_d   = orv_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        under_d = under_q;
        over_d  = over_q;
        if (target_valid) begin
            if (!idle)             over_d  = 1'b1;
            else if (cfifo_rdempty) under_d = 1'b1;
        end
        if (idle) begin
            if (sc_cmd == SC_CMD_BITMASK) mask_d = sc_data;
            else if (sc_switching)        mask_d = '1;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    act_d   = target_out;
                    exp_d   = cfifo_q[CHF_EXP_LSB +: STF_WIDTH];
                    vaddr_d = cfifo_q[CHF_ADDR_LSB +: ADDR_WIDTH];
                    orv_d   = cfifo_q[CHF_ORV_LSB +: ORV_WIDTH];
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (miss) begin
                    if (~&fail_q) fail_d = fail_q + 1'b1;
                end else begin
                    if (~&pass_q) pass_d = pass_q + 1'b1;
                end
                state_d = (log_it && room) ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                if (done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            act_q   <= '0;
            exp_q   <= '0;
            vaddr_q <= '0;
            orv_q   <= '0;
            mask_q  <= '1;
            pass_q  <= '0;
            fail_q  <= '0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            exp_q   <= exp_d;
            vaddr_q <= vaddr_d;
            orv_q   <= orv_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            under_q <= under_d;
            over_q  <= over_d;
        end
    end

    check_rec_writer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RES_BASE   (RES_BASE),
        .RES_LIMIT  (RES_LIMIT)
    ) u_writer (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .rec             (rec),
        .room            (room),
        .done            (done),
        .res_full        (res_full),
        .mem_address     (mem_address),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest)
    );

endmodule
